multi_ff_bank: RTL and testbench

MULTI_FF_BANK -- requirements
Module: multi_ff_bank

---
 rtl/multi_ff_bank.sv | 99 +++++++++
 tb/tb_multi_ff_bank.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/multi_ff_bank.sv
// Bank of WIDTH flip-flops sharing one selectable type (JK/SR/D/T), with a change pulse and saturating change counter.
// Optional sticky SR-illegal flag is built only when MULTI_FF_BANK_ERR_EN is defined.
module multi_ff_lane (
  input  logic [1:0] mode,
  input  logic       a,
  input  logic       b,
  input  logic       q,
  output logic       q_next
);
  always_comb begin
    q_next = q;
    unique case (mode)
      2'b00: begin
        unique case ({a, b})
          2'b00: q_next = q;
          2'b01: q_next = 1'b0;
          2'b10: q_next = 1'b1;
          2'b11: q_next = ~q;
        endcase
      end
      2'b01: begin
        // S=R=1 is illegal for SR; the bit simply holds
        unique case ({a, b})
          2'b01:   q_next = 1'b0;
          2'b10:   q_next = 1'b1;
          default: q_next = q;
        endcase
      end
      2'b10: q_next = a;
      2'b11: q_next = q ^ a;
    endcase
  end
endmodule

module multi_ff_bank #(
  parameter int                    WIDTH   = 8,
  parameter int                    CNT_W   = 8,
  parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             chg,
  output logic [CNT_W-1:0] cnt,
  output logic             err
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] q_next;
  logic             chg_set;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_lane
      multi_ff_lane u_lane (
        .mode   (mode),
        .a      (a[i]),
        .b      (b[i]),
        .q      (q[i]),
        .q_next (q_next[i])
      );
    end
  endgenerate

  assign chg_set = en & (|(q_next ^ q));
  assign qn      = ~q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= RST_VAL;
      chg <= 1'b0;
    end else begin
      if (en) q <= q_next;
      chg <= chg_set;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            cnt <= '0;
    else if (clr)                       cnt <= '0;
    else if (chg_set && cnt != CNT_MAX) cnt <= cnt + 1'b1;
  end

`ifdef MULTI_FF_BANK_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   err <= 1'b0;
    else if (clr)                              err <= 1'b0;
    else if (en && mode == 2'b01 && |(a & b))  err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_multi_ff_bank.sv
// Directed-vector bench for multi_ff_bank (WIDTH=8, CNT_W=4, RST_VAL=0).
module tb_multi_ff_bank;
`ifdef MULTI_FF_BANK_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       clr = 1'b0;
  logic [7:0] q, qn;
  logic       chg;
  logic [3:0] cnt;
  logic       err;

  int checks = 0;
  int failures = 0;

  multi_ff_bank #(.WIDTH(8), .CNT_W(4), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr(clr),
    .q(q), .qn(qn), .chg(chg), .cnt(cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_q", q, 8'h00);
    check("rst_qn", qn, 8'hFF);
    check("rst_chg", chg, 0);
    check("rst_cnt", cnt, 0);
    check("rst_err", err, 0);
    rst = 1'b0;

    // load A5 then async reset between edges
    mode = 2'b10; a = 8'hA5; en = 1'b1; tick();
    check("d_a5_q", q, 8'hA5);
    check("d_a5_chg", chg, 1);
    check("d_a5_cnt", cnt, 1);
    #2 rst = 1'b1;
    #1;
    check("async_q", q, 8'h00);
    check("async_qn", qn, 8'hFF);
    check("async_cnt", cnt, 0);
    check("async_chg", chg, 0);
    rst = 1'b0;

    // JK set/reset then toggle
    mode = 2'b00; a = 8'hF0; b = 8'h0F; tick();
    check("jk1_q", q, 8'hF0);
    check("jk1_chg", chg, 1);
    a = 8'hFF; b = 8'hFF; tick();
    check("jk2_q", q, 8'h0F);
    check("jk2_qn", qn, 8'hF0);
    check("jk2_chg", chg, 1);
    check("jk2_cnt", cnt, 2);

    // SR with illegal bit 0
    mode = 2'b10; a = 8'h3C; tick();
    check("d_3c_q", q, 8'h3C);
    mode = 2'b01; a = 8'h81; b = 8'h01; tick();
    check("sr_q", q, 8'hBC);
    check("sr_err", err, ERR_EN);
    check("sr_cnt", cnt, 4);
    clr = 1'b1; en = 1'b0; tick();
    check("clr_q", q, 8'hBC);
    check("clr_err", err, 0);
    check("clr_cnt", cnt, 0);
    check("clr_chg_en0", chg, 0);
    // clr beats a simultaneous increment
    en = 1'b1; mode = 2'b10; a = 8'h00; tick();
    check("clrinc_q", q, 8'h00);
    check("clrinc_chg", chg, 1);
    check("clrinc_cnt", cnt, 0);
    clr = 1'b0;

    // SR all-illegal holds
    a = 8'hC3; tick();
    check("d_c3_q", q, 8'hC3);
    mode = 2'b01; a = 8'hFF; b = 8'hFF; tick();
    check("srill_q", q, 8'hC3);
    check("srill_chg", chg, 0);
    check("srill_cnt", cnt, 1);
    check("srill_err", err, ERR_EN);

    // T toggling bit 0, counter saturates at 15
    clr = 1'b1; mode = 2'b10; a = 8'h00; tick();
    check("t_pre_q", q, 8'h00);
    check("t_pre_err", err, 0);
    clr = 1'b0; mode = 2'b11; a = 8'h01;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check($sformatf("t_q_%0d", i), q, {7'b0, i[0]});
    end
    check("t_cnt_sat", cnt, 15);
    check("t_chg", chg, 1);

    // D hold: chg only on first edge
    clr = 1'b1; en = 1'b0; tick();
    check("d_pre_cnt", cnt, 0);
    clr = 1'b0; en = 1'b1; mode = 2'b10; a = 8'h55; tick();
    check("d55_1_q", q, 8'h55);
    check("d55_1_chg", chg, 1);
    check("d55_1_cnt", cnt, 1);
    tick();
    check("d55_2_chg", chg, 0);
    tick();
    check("d55_3_chg", chg, 0);
    check("d55_3_cnt", cnt, 1);
    en = 1'b0; a = 8'hAA; tick();
    check("en0_q", q, 8'h55);
    check("en0_chg", chg, 0);
    check("en0_cnt", cnt, 1);

    // inputs ignored while rst held
    rst = 1'b1; en = 1'b1; a = 8'hFF; clr = 1'b0; tick();
    check("rsthold_q", q, 8'h00);
    check("rsthold_cnt", cnt, 0);
    rst = 1'b0; tick();
    check("rstrel_q", q, 8'hFF);
    check("rstrel_cnt", cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
